// File: rtl/fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// fifo_frame_reader
//   Read-side master for a synchronous BRAM FIFO. It reads one frame of
//   FRAME_LEN words, then rewinds the FIFO read pointer and replays the frame
//   until num_passes passes have been sent. Words go out on a valid/ready
//   stream. A 2-entry skid buffer absorbs the 1-cycle BRAM read latency, so
//   back-pressure never drops or duplicates a word.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   start           pulse, accepted only in IDLE; samples num_passes
//   num_passes      number of passes to stream (0 = immediate done)
//   abort           synchronous abort, any state -> IDLE, buffered data dropped
//   busy / done     high from start accept until done/abort / 1-cycle completion pulse
//   fifo_rd_en      FIFO read strobe (data valid on fifo_out one cycle later)
//   fifo_rd_rewind  1-cycle FIFO read-pointer rewind between passes
//   fifo_empty      FIFO empty flag
//   fifo_out        FIFO read data
//   m_valid/m_ready stream handshake
//   m_data          stream word
//   m_last          marks word FRAME_LEN-1 of every pass
//   m_pass_idx      0-based pass number of the word on m_data
// -----------------------------------------------------------------------------
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 784,
    parameter int PASS_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_W-1:0]     num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_rewind,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [PASS_W-1:0]     m_pass_idx
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_REWIND = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [PASS_W-1:0]       num_passes_q, num_passes_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [PASS_W-1:0]       issue_pass_q, issue_pass_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic [PASS_W-1:0]       pass_cnt_q, pass_cnt_d;
    logic                    in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0]   skid_q [0:1];
    logic [DATA_WIDTH-1:0]   skid_d [0:1];
    logic                    head_q, head_d;
    logic [1:0]              fill_q, fill_d;

    logic                    pop_s;
    logic [1:0]              fill_after_pop_s;
    logic                    tail_s;
    logic                    room_s;
    logic                    rd_en_s;
    logic                    last_pass_s;
    logic                    start_accept_s;

    // Stream side is driven straight from the skid buffer registers.
    assign m_valid    = (fill_q != 2'd0);
    assign m_data     = skid_q[head_q];
    assign m_last     = m_valid & (out_cnt_q == LAST_IDX);
    assign m_pass_idx = pass_cnt_q;

    assign pop_s            = m_valid & m_ready;
    assign fill_after_pop_s = fill_q - {1'b0, pop_s};
    // Free slot after this cycle's pop, so the word in flight lands next to it.
    assign tail_s           = head_d ^ fill_after_pop_s[0];
    // Occupancy counted after this cycle's hand-off: keeps held + in-flight
    // words at two or fewer while still allowing one read per cycle.
    assign room_s           = ((fill_after_pop_s + {1'b0, in_flight_q}) < 2'd2);
    assign rd_en_s          = (state_q == S_STREAM) & ~fifo_empty & room_s;
    assign last_pass_s      = (issue_pass_q == (num_passes_q - PASS_W'(1)));
    assign start_accept_s   = (state_q == S_IDLE) & start & ~abort;

    assign fifo_rd_en     = rd_en_s;
    assign fifo_rd_rewind = (state_q == S_REWIND);
    assign busy           = (state_q == S_STREAM) | (state_q == S_REWIND) | (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);

    // Next-state logic of the control FSM; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_passes == {PASS_W{1'b0}}) ? S_DONE : S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (rd_en_s && (issue_cnt_q == LAST_IDX)) begin
                    state_d = last_pass_s ? S_DRAIN : S_REWIND;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_REWIND: begin
                state_d = S_STREAM;
            end
            S_DRAIN: begin
                // Leave as soon as the last buffered word is handed off.
                if (!in_flight_q && (fill_after_pop_s == 2'd0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next values of counters and skid buffer.
    always_comb begin
        num_passes_d = num_passes_q;
        issue_cnt_d  = issue_cnt_q;
        issue_pass_d = issue_pass_q;
        out_cnt_d    = out_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        in_flight_d  = rd_en_s;
        head_d       = head_q ^ pop_s;
        fill_d       = fill_after_pop_s + {1'b0, in_flight_q};
        skid_d       = skid_q;

        // The word read last cycle is on fifo_out now.
        if (in_flight_q) begin
            skid_d[tail_s] = fifo_out;
        end else begin
            skid_d[tail_s] = skid_q[tail_s];
        end

        if (start_accept_s) begin
            num_passes_d = num_passes;
            issue_cnt_d  = {CNT_W{1'b0}};
            issue_pass_d = {PASS_W{1'b0}};
            out_cnt_d    = {CNT_W{1'b0}};
            pass_cnt_d   = {PASS_W{1'b0}};
        end else begin
            if (rd_en_s) begin
                if (issue_cnt_q == LAST_IDX) begin
                    issue_cnt_d  = {CNT_W{1'b0}};
                    issue_pass_d = issue_pass_q + PASS_W'(1);
                end else begin
                    issue_cnt_d  = issue_cnt_q + CNT_W'(1);
                end
            end else begin
                issue_cnt_d = issue_cnt_q;
            end

            // Pass index advances only when the pass's last word leaves, so
            // words of the next pass can never overtake the current one.
            if (pop_s) begin
                if (out_cnt_q == LAST_IDX) begin
                    out_cnt_d  = {CNT_W{1'b0}};
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                end else begin
                    out_cnt_d  = out_cnt_q + CNT_W'(1);
                end
            end else begin
                out_cnt_d = out_cnt_q;
            end
        end
    end

    // Datapath registers; abort clears them like reset, dropping any word
    // still in flight from the FIFO.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            num_passes_q <= {PASS_W{1'b0}};
            issue_cnt_q  <= {CNT_W{1'b0}};
            issue_pass_q <= {PASS_W{1'b0}};
            out_cnt_q    <= {CNT_W{1'b0}};
            pass_cnt_q   <= {PASS_W{1'b0}};
            in_flight_q  <= 1'b0;
            head_q       <= 1'b0;
            fill_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            num_passes_q <= num_passes_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_pass_q <= issue_pass_d;
            out_cnt_q    <= out_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            in_flight_q  <= in_flight_d;
            head_q       <= head_d;
            fill_q       <= fill_d;
            for (int i = 0; i < 2; i++) begin
                skid_q[i] <= skid_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader with a small FIFO model and a queue of the
// words each run must deliver, built from frame contents and pass count.
module tb_fifo_frame_reader;
    localparam int DW = 16;
    localparam int FL = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, fifo_empty, m_ready;
    logic [PW-1:0] num_passes;
    logic [DW-1:0] fifo_out;
    logic          busy, done, fifo_rd_en, fifo_rd_rewind, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic [PW-1:0] m_pass_idx;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .PASS_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .abort(abort),
        .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en), .fifo_rd_rewind(fifo_rd_rewind),
        .fifo_empty(fifo_empty), .fifo_out(fifo_out), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_pass_idx(m_pass_idx)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [PW-1:0] p;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] frame [FL];
    int  n_tests = 0, n_fail = 0;
    int  rd_ptr, wr_ptr, cyc = 0, issued, accepted, accept_cyc;
    int  words, lasts, rewinds, dones, rd_cnt, valid_cnt;
    int  ready_mode, fill_mode;
    bit  model_busy, done_due, prev_stall, check_lat, seen_valid;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic [PW-1:0] prev_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_frame(input bit seq);
        for (int i = 0; i < FL; i++) frame[i] = seq ? DW'(i + 1) : DW'($urandom_range(0, 32767));
    endtask

    // FIFO restarted with n words visible; per-run counters cleared.
    task automatic prep(input int n);
        rd_ptr = 0; wr_ptr = n; fifo_empty = (rd_ptr >= wr_ptr);
        words = 0; lasts = 0; rewinds = 0; dones = 0; rd_cnt = 0; valid_cnt = 0;
    endtask

    // One clock: check the cycle at negedge, then update models after posedge.
    task automatic tick();
        logic hs, rd, rw, st, ab, fin, idle;
        exp_t e;
        @(negedge clk);
        hs = m_valid & m_ready; rd = fifo_rd_en; rw = fifo_rd_rewind; st = start; ab = abort;
        fin = 1'b0;
        if (rd) rd_cnt++;
        if (rw) rewinds++;
        if (done) dones++;
        if (m_valid) valid_cnt++;
        chk("rd_with_rewind", {31'd0, rd & rw}, 32'd0);
        chk("rd_while_empty", {31'd0, rd & fifo_empty}, 32'd0);
        chk("outstanding_le_2", {31'd0, (issued - accepted) <= 2}, 32'd1);
        chk("done", {31'd0, done}, {31'd0, done_due});
        chk("busy", {31'd0, busy}, {31'd0, model_busy});
        if (!model_busy) begin
            chk("idle_valid", {31'd0, m_valid}, 32'd0);
            chk("idle_rd_en", {31'd0, rd}, 32'd0);
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {16'd0, m_data}, {16'd0, prev_d});
            chk("stall_last", {31'd0, m_last}, {31'd0, prev_l});
            chk("stall_pass", {24'd0, m_pass_idx}, {24'd0, prev_p});
        end
        prev_stall = m_valid & ~m_ready; prev_d = m_data; prev_l = m_last; prev_p = m_pass_idx;
        if (check_lat && model_busy && m_valid && !seen_valid) begin
            seen_valid = 1'b1;
            chk("first_valid_latency", cyc - accept_cyc, 32'd2);
        end
        if (hs) begin
            words++;
            if (m_last) lasts++;
            if (exp_q.size() == 0) chk("spurious_word", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("m_data", {16'd0, m_data}, {16'd0, e.d});
                chk("m_last", {31'd0, m_last}, {31'd0, e.l});
                chk("m_pass_idx", {24'd0, m_pass_idx}, {24'd0, e.p});
                fin = model_busy && (exp_q.size() == 0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        idle = !model_busy && !done_due;
        done_due = 1'b0;
        if (hs) accepted++;
        if (rw) rd_ptr = 0;
        if (rd && rd_ptr < wr_ptr) begin
            fifo_out = frame[rd_ptr]; rd_ptr++; issued++;
        end else fifo_out = 16'hDEAD;
        if (ab) begin
            model_busy = 1'b0; exp_q.delete(); issued = 0; accepted = 0; prev_stall = 1'b0;
        end else begin
            if (fin) begin model_busy = 1'b0; done_due = 1'b1; end
            if (st && idle) begin
                if (num_passes == 0) done_due = 1'b1;
                else begin
                    model_busy = 1'b1; accept_cyc = cyc; seen_valid = 1'b0;
                    for (int p = 0; p < int'(num_passes); p++)
                        for (int i = 0; i < FL; i++)
                            exp_q.push_back('{d: frame[i], l: (i == FL - 1), p: PW'(p)});
                end
            end
        end
        if (fill_mode != 0 && wr_ptr < FL && $urandom_range(0, 3) == 0) wr_ptr++;
        fifo_empty = (rd_ptr >= wr_ptr);
        if (ready_mode == 0) m_ready = 1'b1;
        else if (ready_mode == 1) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((model_busy || done_due) && n < budget) begin tick(); n++; end
        if (model_busy || done_due) chk("timeout", 32'd1, 32'd0);
    endtask

    task automatic kick(input int np);
        start = 1'b1; num_passes = PW'(np);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int np, n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_passes = '0; m_ready = 1'b1;
        fifo_out = '0; fifo_empty = 1'b1; ready_mode = 0; fill_mode = 0; check_lat = 1'b0;
        issued = 0; accepted = 0; model_busy = 1'b0; done_due = 1'b0; prev_stall = 1'b0;
        set_frame(1'b1); prep(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_rewind", {31'd0, fifo_rd_rewind}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data", {16'd0, m_data}, 32'd0);
        chk("rst_pass", {24'd0, m_pass_idx}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Single pass 1,2,3,4 with m_ready held high.
        set_frame(1'b1); prep(FL); check_lat = 1'b1;
        kick(1); wait_idle(100); check_lat = 1'b0;
        chk("t1_words", words, 32'd4); chk("t1_lasts", lasts, 32'd1); chk("t1_dones", dones, 32'd1);

        // Three passes, with an ignored start mid-run.
        prep(FL);
        kick(3); repeat (4) tick();
        start = 1'b1; num_passes = 8'd5; tick(); start = 1'b0;
        wait_idle(200);
        chk("t2_words", words, 32'd12); chk("t2_lasts", lasts, 32'd3);
        chk("t2_rewinds", rewinds, 32'd2); chk("t2_dones", dones, 32'd1);

        // Toggled ready, then ready low for 5 cycles mid-pass.
        set_frame(1'b0); prep(FL); ready_mode = 2;
        kick(2);
        for (int i = 0; i < 7; i++) begin m_ready = 1'(i & 1); tick(); end
        m_ready = 1'b0; repeat (5) tick();
        for (int i = 0; i < 6; i++) begin m_ready = 1'(i & 1); tick(); end
        m_ready = 1'b1; ready_mode = 0; wait_idle(200);
        chk("t3_words", words, 32'd8); chk("t3_lasts", lasts, 32'd2);

        // FIFO starts with 2 words; the rest arrive later.
        set_frame(1'b0); prep(2);
        kick(1); repeat (9) tick();
        chk("t4_words_before_gap", words, 32'd2);
        wr_ptr = 3; fifo_empty = (rd_ptr >= wr_ptr);
        repeat (6) tick();
        chk("t4_words_mid", words, 32'd3);
        wr_ptr = 4; fifo_empty = (rd_ptr >= wr_ptr);
        wait_idle(100);
        chk("t4_words", words, 32'd4);

        // Abort at pass 1 word 2, abort+start together, then a clean restart.
        set_frame(1'b1); prep(FL);
        kick(2);
        n = 0;
        while (words < 6 && n < 100) begin tick(); n++; end
        chk("t5_reached_abort_point", words, 32'd6);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_busy_after_abort", {31'd0, busy}, 32'd0);
        chk("t5_valid_after_abort", {31'd0, m_valid}, 32'd0);
        repeat (3) tick();
        start = 1'b1; abort = 1'b1; num_passes = 8'd1; tick(); start = 1'b0; abort = 1'b0;
        chk("t5_abort_beats_start", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        chk("t5_no_done", dones, 32'd0);
        prep(FL);
        kick(1); wait_idle(100);
        chk("t5_restart_words", words, 32'd4); chk("t5_restart_dones", dones, 32'd1);

        // Zero passes: done only, no reads, no valid.
        prep(FL);
        kick(0); wait_idle(10); repeat (2) tick();
        chk("t6_dones", dones, 32'd1); chk("t6_rd_cnt", rd_cnt, 32'd0);
        chk("t6_valid_cnt", valid_cnt, 32'd0);

        // Randomised runs: random frames, pass counts, ready and FIFO fill.
        ready_mode = 1; fill_mode = 1;
        for (int r = 0; r < 8; r++) begin
            set_frame(1'b0); prep($urandom_range(0, FL));
            np = $urandom_range(1, 4);
            kick(np); wait_idle(600);
            chk("rand_words", words, np * FL);
            chk("rand_rewinds", rewinds, np - 1);
            chk("rand_dones", dones, 32'd1);
        end
        ready_mode = 0; fill_mode = 0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
